fpga_reset_sequencer: RTL

//  Board-level reset/boot sequencer between FPGA board pins and the pulpissimo SoC instance.

---
 rtl/fpga_rst_seq_pkg.sv | 20 ++
 rtl/rst_btn_debounce.sv | 49 ++++
 rtl/fpga_reset_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/fpga_rst_seq_pkg.sv
// Shared types and helpers for the board reset/boot sequencer.
// Holds the sequencer state encoding and counter sizing helper.
package fpga_rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        TRST_REL  = 2'd2,
        RUN       = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rst_btn_debounce.sv
// Reset button synchroniser plus stable-for-N-cycles debouncer.
// Output changes only after the synced input disagrees for DEBOUNCE_CYCLES cycles.
module rst_btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_db_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   btn_s;

    assign btn_s    = sync_q[SYNC_STAGES-1];
    assign btn_db_o = db_q;

    // Any sample agreeing with the current level clears the run count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (btn_s != db_q) begin
            if (cnt_q >= LAST) begin
                db_d = btn_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

endmodule

// File: rtl/fpga_reset_sequencer.sv
// Board-level reset/boot sequencer: orders JTAG TRST and SoC reset release
// after PLL lock and a debounced reset button, latching boot select.
module fpga_reset_sequencer
    import fpga_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int HOLD_CYCLES      = 64,
    parameter int TRST_LEAD_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pll_locked_i,
    input  logic btn_reset_i,
    input  logic bootsel_i,
    output logic soc_rst_no,
    output logic jtag_trst_no,
    output logic bootsel_o,
    output logic ready_o
);

    localparam int CW = $clog2(
        max3(HOLD_CYCLES, TRST_LEAD_CYCLES, DEBOUNCE_CYCLES) + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TRST_LAST = CW'(TRST_LEAD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lk_sync_q;
    logic [SYNC_STAGES-1:0] bs_sync_q;
    logic                   lk;
    logic                   bs_s;
    logic                   btn_db;
    logic                   btn_prev_q;
    state_e                 state_q;
    logic [CW-1:0]          cnt_q;

    assign lk   = lk_sync_q[SYNC_STAGES-1];
    assign bs_s = bs_sync_q[SYNC_STAGES-1];

    rst_btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_reset_i),
        .btn_db_o(btn_db)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lk_sync_q <= '0;
            bs_sync_q <= '0;
        end else begin
            lk_sync_q <= {lk_sync_q[SYNC_STAGES-2:0], pll_locked_i};
            bs_sync_q <= {bs_sync_q[SYNC_STAGES-2:0], bootsel_i};
        end
    end

    // Lock loss outranks button and terminal count in every active state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            btn_prev_q   <= 1'b0;
            soc_rst_no   <= 1'b0;
            jtag_trst_no <= 1'b0;
            bootsel_o    <= 1'b0;
            ready_o      <= 1'b0;
        end else begin
            btn_prev_q <= btn_db;
            if (state_q != WAIT_LOCK && !lk) begin
                state_q      <= WAIT_LOCK;
                cnt_q        <= '0;
                soc_rst_no   <= 1'b0;
                jtag_trst_no <= 1'b0;
                ready_o      <= 1'b0;
            end else begin
                unique case (state_q)
                    WAIT_LOCK: begin
                        cnt_q <= '0;
                        if (lk) state_q <= HOLD;
                    end
                    HOLD: begin
                        if (btn_db) begin
                            cnt_q <= '0;
                        end else if (cnt_q >= HOLD_LAST) begin
                            state_q      <= TRST_REL;
                            cnt_q        <= '0;
                            jtag_trst_no <= 1'b1;
                            bootsel_o    <= bs_s;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    TRST_REL: begin
                        if (cnt_q >= TRST_LAST) begin
                            state_q    <= RUN;
                            cnt_q      <= '0;
                            soc_rst_no <= 1'b1;
                            ready_o    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                        if (btn_db && !btn_prev_q) begin
                            state_q      <= HOLD;
                            cnt_q        <= '0;
                            soc_rst_no   <= 1'b0;
                            jtag_trst_no <= 1'b0;
                            ready_o      <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
